// File: rtl/switch_debouncer_if.sv
// ----------------------------------------------------------------------------
// switch_debouncer_if
//
// Purpose : bundles the switch-side and clean-side signals of the
//           multi-channel switch debouncer.
//
// Signals (all WIDTH bits):
//   in     : raw, asynchronous switch levels (driven by the board / master)
//   out    : debounced level, registered
//   rise   : one-cycle pulse when out[i] goes 0->1
//   fall   : one-cycle pulse when out[i] goes 1->0
//   toggle : flips on each debounced rising edge (constant 0 unless the
//            debouncer is built with SWITCH_TOGGLE_EN)
//
// Modports:
//   master : drives in, observes the debounced outputs
//   slave  : the debouncer itself
// ----------------------------------------------------------------------------
interface switch_debouncer_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] toggle;

    modport master (
        output in,
        input  out,
        input  rise,
        input  fall,
        input  toggle
    );

    modport slave (
        input  in,
        output out,
        output rise,
        output fall,
        output toggle
    );

endinterface

// File: rtl/switch_debouncer.sv
// ----------------------------------------------------------------------------
// switch_debouncer
//
// Purpose : multi-channel debouncer for mechanical switch inputs. Every
//           channel has a two-flop synchroniser, a stability counter and a
//           registered clean output with one-cycle rise / fall pulses.
//           Channels are fully independent; they share only clk and rst.
//
// Parameters:
//   WIDTH         : number of switch channels (>= 1)
//   STABLE_CYCLES : consecutive synchronised cycles a new level must hold
//                   before it is accepted (>= 2)
//   CNT_W         : counter width, 2**CNT_W > STABLE_CYCLES
//
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous, active-high reset
//   sw          : switch_debouncer_if.slave (in / out / rise / fall / toggle)
//   dbg_pending : per-channel FSM state, 1 = PENDING, 0 = STABLE
//
// Configuration macro:
//   SWITCH_TOGGLE_EN : when defined, toggle[i] flips on the same edge that
//                      raises rise[i]. When undefined, toggle is tied to 0
//                      and no toggle registers exist.
//
// Handshake: there is no valid/ready flow control. in is sampled on every
// clock; out / rise / fall / toggle are registered and change only on the
// rising edge of clk. A level change sampled at edge E is visible on out
// after edge E+STABLE_CYCLES+1, together with its rise or fall pulse.
// ----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_debouncer_if.slave    sw,
    output logic [WIDTH-1:0]     dbg_pending
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Per-channel FSM and counter
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    // accept[i]: the pending level on channel i has held long enough
    logic [WIDTH-1:0] accept;

    // Registered outputs and their next values
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // ------------------------------------------------------------------
    // State register (synchroniser, FSM, counter, registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1     <= sw.in;
            s2     <= s1;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (s2[i] != out_q[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_PENDING: begin
                    if (s2[i] == out_q[i]) begin
                        // Bounced back before the count finished: drop it.
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        accept[i]  = 1'b1;
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs, plus the
    // debug view of the FSM.
    // ------------------------------------------------------------------
    always_comb begin
        // An accepted channel always differs from out, so flipping is the
        // same as loading s2.
        out_d  = out_q ^ accept;
        rise_d = accept & s2;
        fall_d = accept & ~s2;
        dbg_pending = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dbg_pending[i] = (state_q[i] == ST_PENDING);
        end
    end

    assign sw.out  = out_q;
    assign sw.rise = rise_q;
    assign sw.fall = fall_q;

`ifdef SWITCH_TOGGLE_EN
    logic [WIDTH-1:0] toggle_q;

    // Flips on the same edge that loads rise_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_q ^ rise_d;
        end
    end

    assign sw.toggle = toggle_q;
`else
    assign sw.toggle = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// ----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed bench for switch_debouncer (WIDTH=4, STABLE_CYCLES=8).
// A behavioural model keeps the full history of sampled inputs since reset
// and decides each cycle whether the last STABLE_CYCLES synchronised samples
// all disagree with the current clean level; a compare process checks the
// DUT against it on every falling edge. Literal checks pin exact latencies.
// ----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int SC = 8;

  // --------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) sw ();
  logic [W-1:0] dbg_pending;

  switch_debouncer #(
    .WIDTH(W),
    .STABLE_CYCLES(SC),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .dbg_pending(dbg_pending)
  );

  int checks   = 0;
  int failures = 0;
  logic started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------
  // Behavioural model: synchronised level at edge k is the input sampled
  // at edge k-2 (0 before reset release). Out flips at edge k when the
  // STABLE_CYCLES synchronised levels seen at edges k-SC+1..k all differ
  // from the current clean level.
  // --------------------------------------------------------------------
  logic [W-1:0] hist [$];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  logic [W-1:0] m_tog  = '0;

  always @(posedge clk) begin
    int k;
    int idx;
    logic all_diff;
    logic [W-1:0] smp;
    logic [W-1:0] n_out;
    if (rst) begin
      hist.delete();
      m_out  = '0;
      m_rise = '0;
      m_fall = '0;
      m_tog  = '0;
    end else begin
      hist.push_back(sw.in);
      k = hist.size() - 1;
      n_out  = m_out;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < SC; j++) begin
          idx = k - 2 - j;
          if (idx >= 0) smp = hist[idx];
          else smp = '0;
          if (smp[i] == m_out[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          n_out[i] = ~m_out[i];
          if (n_out[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
        end
      end
      m_out = n_out;
`ifdef SWITCH_TOGGLE_EN
      m_tog = m_tog ^ m_rise;
`endif
    end
  end

  // --------------------------------------------------------------------
  // Compare process
  // --------------------------------------------------------------------
  always @(negedge clk) begin
    if (started) begin
      check("model_out", sw.out, m_out);
      check("model_rise", sw.rise, m_rise);
      check("model_fall", sw.fall, m_fall);
      check("model_toggle", sw.toggle, m_tog);
      check("rise_fall_excl", sw.rise & sw.fall, '0);
    end
  end

  // --------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [W-1:0] v);
    sw.in = v;
  endtask

  // --------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------
  logic [W-1:0] exp_tog;

  initial begin
    sw.in = 4'b1111;
    rst   = 1'b1;

    // Reset held for 3 cycles with all inputs high
    for (int c = 0; c < 3; c++) begin
      tick(1);
      started = 1'b1;
      check("rst_out", sw.out, 4'b0000);
      check("rst_rise", sw.rise, 4'b0000);
      check("rst_fall", sw.fall, 4'b0000);
      check("rst_toggle", sw.toggle, 4'b0000);
    end
    rst = 1'b0;
    tick(9);
    check("rst_rel_out_e9", sw.out, 4'b0000);
    tick(1);
    check("rst_rel_out_e10", sw.out, 4'b1111);
    check("rst_rel_rise_e10", sw.rise, 4'b1111);
    tick(1);
    check("rst_rel_rise_e11", sw.rise, 4'b0000);
    check("rst_rel_out_e11", sw.out, 4'b1111);

    // All low again: fall on every channel
    set_in(4'b0000);
    tick(10);
    check("all_fall_e10", sw.fall, 4'b1111);
    check("all_fall_out", sw.out, 4'b0000);
    tick(2);

    // Multi-channel: 0000 -> 1010 in one cycle
    set_in(4'b1010);
    tick(9);
    check("multi_out_e9", sw.out, 4'b0000);
    tick(1);
    check("multi_out_e10", sw.out, 4'b1010);
    check("multi_rise_e10", sw.rise, 4'b1010);
    tick(1);
    check("multi_rise_e11", sw.rise, 4'b0000);
    set_in(4'b0000);
    tick(12);
    check("multi_back_out", sw.out, 4'b0000);

    // Clean edge on channel 0, then release
    set_in(4'b0001);
    tick(9);
    check("clean_out_e9", sw.out, 4'b0000);
    tick(1);
    check("clean_out_e10", sw.out, 4'b0001);
    check("clean_rise_e10", sw.rise, 4'b0001);
    tick(1);
    check("clean_rise_e11", sw.rise, 4'b0000);
    tick(5);
    set_in(4'b0000);
    tick(9);
    check("clean_fall_out_e9", sw.out, 4'b0001);
    tick(1);
    check("clean_fall_out_e10", sw.out, 4'b0000);
    check("clean_fall_e10", sw.fall, 4'b0001);
    tick(1);
    check("clean_fall_e11", sw.fall, 4'b0000);
    tick(3);

    // Bounce on channel 1: toggles every 3 cycles, ends high
    for (int t = 0; t < 15; t++) begin
      sw.in[1] = ~sw.in[1];
      if (t < 14) begin
        for (int c = 0; c < 3; c++) begin
          tick(1);
          check("bounce_out1", {31'd0, sw.out[1]}, 32'd0);
          check("bounce_edges1", {30'd0, sw.rise[1], sw.fall[1]}, 32'd0);
        end
      end
    end
    tick(9);
    check("bounce_out_e9", sw.out, 4'b0000);
    tick(1);
    check("bounce_out_e10", sw.out, 4'b0010);
    check("bounce_rise_e10", sw.rise, 4'b0010);
    set_in(4'b0000);
    tick(12);
    check("bounce_back_out", sw.out, 4'b0000);

    // Reset mid-count on channel 2
    set_in(4'b0100);
    tick(5);
    check("midcnt_pending", dbg_pending, 4'b0100);
    rst = 1'b1;
    tick(2);
    check("midcnt_rst_out", sw.out, 4'b0000);
    check("midcnt_rst_rise", sw.rise, 4'b0000);
    rst = 1'b0;
    tick(9);
    check("midcnt_out_e9", sw.out, 4'b0000);
    tick(1);
    check("midcnt_out_e10", sw.out, 4'b0100);
    check("midcnt_rise_e10", sw.rise, 4'b0100);
    tick(2);

    // Toggle: three presses on channel 0, 20 cycles high / 20 cycles low
    for (int p = 0; p < 3; p++) begin
      set_in(4'b0101);
      tick(10);
      check("tog_rise0", {31'd0, sw.rise[0]}, 32'd1);
`ifdef SWITCH_TOGGLE_EN
      exp_tog = (p == 1) ? 4'b0000 : 4'b0001;
      exp_tog[2] = 1'b1;
`else
      exp_tog = 4'b0000;
`endif
      check("tog_value", sw.toggle, exp_tog);
      tick(10);
      set_in(4'b0100);
      tick(20);
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
